// File: rtl/pipe_ctrl_if.sv
// Pipeline control interface: groups the hazard/memory/branch/irq inputs
// and the per-stage enable/flush outputs of pipe_ctrl.
//   master : the pipeline environment (drives requests, receives controls)
//   slave  : pipe_ctrl (receives requests, drives controls)
interface pipe_ctrl_if;
    // requests into the sequencer
    logic wpcir;        // 0 = interlock, PC and IF/ID hold
    logic hz_flush;     // bubble into ID/EX
    logic redirect;     // taken branch/jump in ID
    logic imem_ready;   // instruction word valid
    logic dmem_req;     // MEM stage accesses data memory
    logic dmem_ready;   // data access completes
    logic irq;          // level interrupt request
    // controls out of the sequencer
    logic pc_en;
    logic pc_sel_vec;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
    logic irq_ack;
    logic busy;

    modport master (
        output wpcir, hz_flush, redirect, imem_ready, dmem_req, dmem_ready, irq,
        input  pc_en, pc_sel_vec, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_en, irq_ack, busy
    );

    modport slave (
        input  wpcir, hz_flush, redirect, imem_ready, dmem_req, dmem_ready, irq,
        output pc_en, pc_sel_vec, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_en, irq_ack, busy
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage pipeline.
// Merges interlock, memory waits, branch redirect and interrupt request into
// per-stage enables and bubble controls. An interrupt drains the pipe for
// DRAIN_CYCLES cycles, then vectors the PC for one cycle.
// Ports:
//   clk       core clock
//   rst_n     asynchronous active-low reset
//   bus       pipe_ctrl_if.slave (requests in, stage controls out)
//   stall_cnt / flush_cnt  performance counters, present only when the
//             macro PIPE_PERF_CNT_EN is defined
// Outputs are combinational from the registered FSM state and current inputs.
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned DRAIN_W      = 2,
    parameter int unsigned PERF_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_ctrl_if.slave       bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);

    if (DRAIN_CYCLES < 1 || (2 ** DRAIN_W) <= DRAIN_CYCLES) begin : g_bad_drain_cfg
        $error("pipe_ctrl: DRAIN_W too narrow for DRAIN_CYCLES");
    end
    if (PERF_W < 1) begin : g_bad_perf_cfg
        $error("pipe_ctrl: PERF_W must be at least 1");
    end

    typedef enum logic [1:0] {RUN, DRAIN, VECTOR} state_t;

    state_t             state;
    logic [DRAIN_W-1:0] cnt;
    logic               post_vec;   // first RUN cycle after VECTOR ignores irq

    logic mem_wait;
    logic interlock;
    logic pc_en, pc_sel_vec, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, memwb_en, irq_ack;

    assign mem_wait  = bus.dmem_req & ~bus.dmem_ready;
    assign interlock = ~bus.wpcir;

    always_comb begin
        pc_en      = 1'b0;
        pc_sel_vec = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_en    = 1'b0;
        idex_flush = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        irq_ack    = 1'b0;
        if (!rst_n) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (!mem_wait) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            idex_flush = interlock | bus.hz_flush;
            unique case (state)
                RUN: begin
                    if (interlock) begin
                        pc_en   = 1'b0;
                        ifid_en = 1'b0;
                    end else if (bus.hz_flush) begin
                        // bubble into ID/EX only; redirect waits
                    end else if (bus.redirect) begin
                        ifid_flush = 1'b1;
                    end else if (!bus.imem_ready) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    // fetch suppressed; a redirect here is covered by the IF/ID squash
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
                VECTOR: begin
                    pc_sel_vec = 1'b1;
                    irq_ack    = 1'b1;
                    ifid_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_en      = pc_en;
    assign bus.pc_sel_vec = pc_sel_vec;
    assign bus.ifid_en    = ifid_en;
    assign bus.ifid_flush = ifid_flush;
    assign bus.idex_en    = idex_en;
    assign bus.idex_flush = idex_flush;
    assign bus.exmem_en   = exmem_en;
    assign bus.memwb_en   = memwb_en;
    assign bus.irq_ack    = irq_ack;
    assign bus.busy       = (state != RUN);

    // A memory wait freezes the sequencer in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            cnt      <= '0;
            post_vec <= 1'b0;
        end else if (!mem_wait) begin
            unique case (state)
                RUN: begin
                    post_vec <= 1'b0;
                    if (bus.irq && !interlock && !post_vec) begin
                        state <= DRAIN;
                        cnt   <= DRAIN_W'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    cnt <= cnt - DRAIN_W'(1);
                    if (cnt == DRAIN_W'(1)) state <= VECTOR;
                end
                VECTOR: begin
                    state    <= RUN;
                    post_vec <= 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en)                    stall_cnt <= stall_cnt + PERF_W'(1);
            if (ifid_flush || idex_flush)  flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations plus randomized stimulus against a behavioural model.
// Output vector order: {pc_en, pc_sel_vec, ifid_en, ifid_flush, idex_en,
// idex_flush, exmem_en, memwb_en, irq_ack, busy}.
// Input vector order: {wpcir, hz_flush, redirect, imem_ready, dmem_req,
// dmem_ready, irq}.
module tb_pipe_ctrl;
    localparam int D      = 3;
    localparam int PERF_W = 4;

    localparam logic [6:0] IDLE  = 7'b1001010;
    localparam logic [6:0] ILCK  = 7'b0001010;
    localparam logic [6:0] IRQ   = 7'b1001011;
    localparam logic [6:0] MW    = 7'b1001100;
    localparam logic [6:0] MWRIL = 7'b0011100;
    localparam logic [6:0] RIL   = 7'b0011000;

    localparam logic [9:0] RESET_O = 10'b0001010000;
    localparam logic [9:0] IDLE_O  = 10'b1010101100;
    localparam logic [9:0] ILCK_O  = 10'b0000111100;
    localparam logic [9:0] DRAIN_O = 10'b0011101101;
    localparam logic [9:0] VEC_O   = 10'b1111101111;
    localparam logic [9:0] FRZ_O   = 10'b0000000000;
    localparam logic [9:0] FRZB_O  = 10'b0000000001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt, flush_cnt;
`endif

    pipe_ctrl #(.DRAIN_CYCLES(D), .DRAIN_W(2), .PERF_W(PERF_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    logic [9:0] got;
    assign got = {bus.pc_en, bus.pc_sel_vec, bus.ifid_en, bus.ifid_flush, bus.idex_en,
                  bus.idex_flush, bus.exmem_en, bus.memwb_en, bus.irq_ack, bus.busy};

    int total = 0;
    int bad   = 0;

    // Model: seq_pos = 0 outside an interrupt sequence, 1..D = k-th drain
    // cycle, D+1 = vector cycle. Advances only on cycles without a memory wait.
    int   seq_pos  = 0;
    logic just_vec = 1'b0;
    int   acks     = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    function automatic logic [9:0] model_out(input logic [6:0] in, input logic rst, input int pos);
        logic wp, hz, rd, im, dq, dr;
        logic pc, vec, ie, ifl, xfl, ack, bsy;
        {wp, hz, rd, im, dq, dr} = in[6:1];
        if (!rst) return RESET_O;
        bsy = (pos != 0);
        if (dq && !dr) return {9'b0, bsy};
        pc = 1'b1; vec = 1'b0; ie = 1'b1; ifl = 1'b0; ack = 1'b0;
        xfl = !wp || hz;
        if (pos == 0) begin
            if (!wp)      begin pc = 1'b0; ie = 1'b0; end
            else if (hz)  ;
            else if (rd)  ifl = 1'b1;
            else if (!im) begin pc = 1'b0; ifl = 1'b1; end
        end else if (pos <= D) begin
            pc = 1'b0; ifl = 1'b1;
        end else begin
            vec = 1'b1; ack = 1'b1; ifl = 1'b1;
        end
        return {pc, vec, ie, ifl, 1'b1, xfl, 1'b1, 1'b1, ack, bsy};
    endfunction

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Applies one cycle of stimulus, compares mid-cycle, then advances the model.
    task automatic step(input logic [6:0] in, input logic rst, input logic chk,
                        input logic [9:0] lit, input string nm);
        logic [9:0] exp;
        rst_n = rst;
        {bus.wpcir, bus.hz_flush, bus.redirect, bus.imem_ready,
         bus.dmem_req, bus.dmem_ready, bus.irq} = in;
        if (!rst) begin
            seq_pos = 0; just_vec = 1'b0; m_stall = 0; m_flush = 0;
        end
        exp = model_out(in, rst, seq_pos);
        @(negedge clk);
        check({nm, "/model"}, got, exp);
        if (chk) check({nm, "/lit"}, got, lit);
`ifdef PIPE_PERF_CNT_EN
        check({nm, "/stall_cnt"}, {6'b0, stall_cnt}, 10'(m_stall % (1 << PERF_W)));
        check({nm, "/flush_cnt"}, {6'b0, flush_cnt}, 10'(m_flush % (1 << PERF_W)));
`endif
        @(posedge clk);
        if (rst) begin
            if (exp[1]) acks++;
            if (!exp[9]) m_stall++;
            if (exp[6] || exp[4]) m_flush++;
            if (!(in[2] && !in[1])) begin
                if (seq_pos == 0) begin
                    if (in[0] && in[6] && !just_vec) seq_pos = 1;
                    just_vec = 1'b0;
                end else if (seq_pos <= D) begin
                    seq_pos++;
                end else begin
                    seq_pos  = 0;
                    just_vec = 1'b1;
                end
            end
        end
        #1;
    endtask

    initial begin
        int a0;
        logic [6:0] r;

        step(IDLE, 1'b0, 1'b1, RESET_O, "reset");
        step(IDLE, 1'b1, 1'b1, IDLE_O, "first_run");
        step(ILCK, 1'b1, 1'b1, ILCK_O, "interlock");
        step(IDLE, 1'b1, 1'b1, IDLE_O, "after_interlock");

        for (int i = 0; i < 4; i++) step(MWRIL, 1'b1, 1'b1, FRZ_O, "mem_freeze");
        step(RIL, 1'b1, 1'b1, ILCK_O, "interlock_after_freeze");

        a0 = acks;
        step(IRQ, 1'b1, 1'b1, IDLE_O, "irq_take");
        for (int i = 0; i < D; i++) step(IDLE, 1'b1, 1'b1, DRAIN_O, "drain");
        step(IDLE, 1'b1, 1'b1, VEC_O, "vector");
        step(IRQ, 1'b1, 1'b1, IDLE_O, "irq_ignored_after_vec");
        step(IDLE, 1'b1, 1'b1, IDLE_O, "run_after_ignore");
        check("single_ack", 10'(acks - a0), 10'd1);

        a0 = acks;
        step(IRQ, 1'b1, 1'b1, IDLE_O, "irq_take2");
        step(IDLE, 1'b1, 1'b1, DRAIN_O, "drain2_1");
        step(MW, 1'b1, 1'b1, FRZB_O, "drain2_wait");
        step(MW, 1'b1, 1'b1, FRZB_O, "drain2_wait");
        step(IDLE, 1'b1, 1'b1, DRAIN_O, "drain2_2");
        step(IDLE, 1'b1, 1'b1, DRAIN_O, "drain2_3");
        step(MW, 1'b1, 1'b1, FRZB_O, "vector_wait");
        step(IDLE, 1'b1, 1'b1, VEC_O, "vector2");
        step(IDLE, 1'b1, 1'b1, IDLE_O, "run2");
        check("single_ack2", 10'(acks - a0), 10'd1);

        a0 = acks;
        step(IRQ, 1'b1, 1'b1, IDLE_O, "irq_take3");
        step(IDLE, 1'b1, 1'b1, DRAIN_O, "drain3");
        step(IDLE, 1'b0, 1'b1, RESET_O, "reset_mid_drain");
        step(IDLE, 1'b1, 1'b1, IDLE_O, "run_after_abort");
        step(IDLE, 1'b1, 1'b1, IDLE_O, "run_after_abort2");
        check("no_ack_after_abort", 10'(acks - a0), 10'd0);

        step(IDLE, 1'b0, 1'b1, RESET_O, "reset_before_stall");
        for (int i = 0; i < 17; i++) step(ILCK, 1'b1, 1'b1, ILCK_O, "interlock_run");
        step(IDLE, 1'b0, 1'b1, RESET_O, "reset_pulse");

        for (int i = 0; i < 3000; i++) begin
            r[6] = ($urandom % 8) != 0;
            r[5] = ($urandom % 8) == 0;
            r[4] = ($urandom % 6) == 0;
            r[3] = ($urandom % 5) != 0;
            r[2] = ($urandom % 3) == 0;
            r[1] = $urandom_range(0, 1) != 0;
            r[0] = ($urandom % 12) == 0;
            step(r, ($urandom % 400) != 0, 1'b0, '0, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It merges the hazard unit's interlock (wpcir/flush), instruction- and data-memory wait signals, the taken-branch redirect and an external interrupt request. From these it produces per-stage register enables and bubble (flush) controls. A small FSM drains the pipe and vectors the PC on interrupts; memory waits freeze the whole pipe.

Parameters:
DRAIN_CYCLES, 3, cycles of fetch suppression before vectoring an IRQ (in-flight instructions retire)
DRAIN_W, 2, width of drain counter; must satisfy 2^DRAIN_W > DRAIN_CYCLES
PERF_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wpcir  in  1  from hazard unit; 0 = load-use/branch interlock, PC and IF/ID must hold
hz_flush  in  1  from hazard unit; 1 = insert bubble into ID/EX
redirect  in  1  branch/jump taken in ID; squash the instruction in IF
imem_ready  in  1  instruction word valid this cycle
dmem_req  in  1  MEM-stage instruction accesses data memory
dmem_ready  in  1  data access completes this cycle
irq  in  1  level interrupt request
pc_en  out  1  PC register load enable
pc_sel_vec  out  1  PC mux selects interrupt vector
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID loads NOP
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX loads NOP
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
irq_ack  out  1  one-cycle acknowledge, coincident with vector load
busy  out  1  FSM not in RUN

Behaviour:
- Reset (rst_n=0, async): state=RUN, drain counter=0. While low, all *_en=0, pc_sel_vec=0, irq_ack=0, ifid_flush=idex_flush=1, busy=0.
- Outputs are combinational from registered state plus current inputs (zero-latency freeze). Only the FSM and counter are registered.
- mem_wait = dmem_req & ~dmem_ready.
- Priority within a cycle (highest first):
  1. mem_wait: all enables 0, flushes 0. The whole pipe freezes, including during DRAIN.
  2. Interlock (wpcir=0): pc_en=ifid_en=0; idex_en=1; idex_flush=1; exmem_en=memwb_en=1. redirect is ignored that cycle.
  3. hz_flush=1 with wpcir=1: idex_flush=1; all other enables 1.
  4. redirect=1: ifid_flush=1; pc_en=1; rest advance.
  5. imem_ready=0: pc_en=0, ifid_flush=1 (bubble into ID); downstream enables 1.
  6. Otherwise all enables 1, flushes 0.
- FSM states: RUN, DRAIN, VECTOR.
  - RUN -> DRAIN when irq=1 and no mem_wait/interlock this cycle. The counter loads DRAIN_CYCLES.
  - DRAIN: pc_en=0, ifid_flush=1, ID/EX and later advance. The counter decrements each non-mem_wait cycle. At 1 (before decrement), go to VECTOR.
  - VECTOR (exactly 1 cycle unless mem_wait): pc_en=1, pc_sel_vec=1, irq_ack=1, ifid_flush=1, then RUN. mem_wait in VECTOR holds the state, with irq_ack=0 until the cycle completes.
  - irq dropping during DRAIN/VECTOR does not abort the sequence. irq is not re-sampled until back in RUN, and the first RUN cycle after VECTOR ignores irq.
- redirect arriving during DRAIN is honoured for the PC only as a squash. DRAIN still forces ifid_flush, and vectoring overrides the PC.
- busy=1 in DRAIN and VECTOR.
- Reset asserted mid-DRAIN aborts immediately; there is no irq_ack.

Optional Feature:
PIPE_PERF_CNT_EN: when defined, adds outputs stall_cnt[PERF_W-1:0] and flush_cnt[PERF_W-1:0]. stall_cnt increments each cycle with pc_en=0. flush_cnt increments each cycle with ifid_flush|idex_flush asserted (excluding reset). Both counters wrap at 2^PERF_W and clear on reset. When undefined, no counters or ports exist and behaviour is otherwise identical.

Test Plan:
- Reset release, all inputs idle-ready (wpcir=1, imem_ready=1) -> first cycle all *_en=1, flushes=0, busy=0.
- wpcir=0 for 1 cycle -> pc_en=ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; next cycle all enables 1.
- dmem_req=1, dmem_ready=0 for 4 cycles with redirect=1 and wpcir=0 simultaneously -> all enables 0 and no flushes for 4 cycles; the 5th cycle applies the interlock.
- irq=1 for 1 cycle in RUN, DRAIN_CYCLES=3 -> 3 cycles pc_en=0/ifid_flush=1, then 1 cycle pc_sel_vec=irq_ack=1, then RUN.
- irq sequence with mem_wait injected for 2 cycles in the 2nd DRAIN cycle -> total DRAIN length 5 cycles; irq_ack still a single pulse.
- With PIPE_PERF_CNT_EN, PERF_W=4: 17 interlock cycles -> stall_cnt reads 1 (wrap); rst_n pulse mid-count -> both counters 0.
